decoder_arbiter: RTL and testbench

- Round-robin arbiter for four requesters sharing the 2-to-4 decoder with enable.
- Selects one requester at a time and drives the decoder's `in`/`en` inputs with the grantee index.
- Presents the matching one-hot grant to the requesters.
- Holds each grant until the grantee releases it; an optional hold timeout can force release.

---
 rtl/decoder_arbiter.sv | 127 ++++++++++++
 tb/tb_decoder_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter that owns a 2-to-4 decoder on behalf of four requesters.
// Optional forced release after MAX_HOLD grant cycles: define DECODER_ARBITER_TIMEOUT_EN.
module decoder_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] dec_in,
   output logic       dec_en,
   output logic [3:0] gnt,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t     state, nxt_state;
   logic [1:0] ptr, nxt_ptr;
   logic [1:0] idx, nxt_idx;
   logic       en, nxt_en;
   logic [3:0] gnt_r, nxt_gnt;
   logic       to_r, nxt_to;
   logic       release_now;

   if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_max_hold
      $error("decoder_arbiter: MAX_HOLD out of range for CNT_W");
   end

   // First set request bit scanning ptr, ptr+1, ... modulo 4.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] c;
      pick = p;
      for (int i = 3; i >= 0; i--) begin
         c = p + 2'(i);
         if (r[c]) pick = c;
      end
   endfunction

`ifdef DECODER_ARBITER_TIMEOUT_EN
   logic [CNT_W-1:0] cnt, nxt_cnt;
`endif

   assign release_now = done | ~req[idx];

   always_comb begin
      nxt_state = state;
      nxt_ptr   = ptr;
      nxt_idx   = idx;
      nxt_en    = en;
      nxt_gnt   = gnt_r;
      nxt_to    = 1'b0;
`ifdef DECODER_ARBITER_TIMEOUT_EN
      nxt_cnt   = cnt;
`endif
      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               nxt_idx   = pick(req, ptr);
               nxt_en    = 1'b1;
               nxt_gnt   = 4'b0001 << pick(req, ptr);
               nxt_state = GRANT;
`ifdef DECODER_ARBITER_TIMEOUT_EN
               nxt_cnt   = '0;
`endif
            end
         end
         GRANT: begin
            if (release_now) begin
               nxt_en    = 1'b0;
               nxt_gnt   = 4'b0000;
               nxt_ptr   = idx + 2'd1;
               nxt_state = IDLE;
`ifdef DECODER_ARBITER_TIMEOUT_EN
            end else if (cnt == CNT_W'(MAX_HOLD - 1)) begin
               // Grant has now been visible for MAX_HOLD cycles.
               nxt_en    = 1'b0;
               nxt_gnt   = 4'b0000;
               nxt_ptr   = idx + 2'd1;
               nxt_state = IDLE;
               nxt_to    = 1'b1;
            end else begin
               nxt_cnt   = cnt + 1'b1;
`endif
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 2'd0;
         idx   <= 2'd0;
         en    <= 1'b0;
         gnt_r <= 4'b0000;
         to_r  <= 1'b0;
`ifdef DECODER_ARBITER_TIMEOUT_EN
         cnt   <= '0;
`endif
      end else begin
         state <= nxt_state;
         ptr   <= nxt_ptr;
         idx   <= nxt_idx;
         en    <= nxt_en;
         gnt_r <= nxt_gnt;
         to_r  <= nxt_to;
`ifdef DECODER_ARBITER_TIMEOUT_EN
         cnt   <= nxt_cnt;
`endif
      end
   end

   assign dec_in  = idx;
   assign dec_en  = en;
   assign busy    = en;
   assign gnt     = gnt_r;
`ifdef DECODER_ARBITER_TIMEOUT_EN
   assign timeout = to_r;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_arbiter.sv
// Directed bench for decoder_arbiter: per-cycle vector table plus hold/timeout sequence.
module tb_decoder_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [1:0] dec_in;
   logic       dec_en;
   logic [3:0] gnt;
   logic       busy;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] gnt;
      logic [1:0] din;
      logic       en;
   } vec_t;

   vec_t vecs[$];

   decoder_arbiter #(
`ifdef DECODER_ARBITER_TIMEOUT_EN
      .MAX_HOLD(4),
`else
      .MAX_HOLD(8),
`endif
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .done(done),
      .dec_in(dec_in),
      .dec_en(dec_en),
      .gnt(gnt),
      .busy(busy),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [3:0] q, input logic d,
                      input logic [3:0] g, input logic [1:0] di, input logic e);
      vec_t v;
      v.rst = r; v.req = q; v.done = d; v.gnt = g; v.din = di; v.en = e;
      vecs.push_back(v);
   endtask

   // Compares {gnt, dec_in, dec_en, busy, timeout} against the expected tuple.
   task automatic check(input string name, input logic [3:0] g, input logic [1:0] di,
                        input logic e, input logic t);
      logic [8:0] act, exp;
      act = {gnt, dec_in, dec_en, busy, timeout};
      exp = {g, di, e, e, t};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got gnt=%b dec_in=%0d dec_en=%b busy=%b timeout=%b, want gnt=%b dec_in=%0d dec_en=%b busy=%b timeout=%b",
                  name, gnt, dec_in, dec_en, busy, timeout, g, di, e, e, t);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] q, input logic d);
      rst = r; req = q; done = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; done = 1'b0;

      // reset with all requests asserted
      add(1, 4'hF, 0, 4'b0000, 2'd0, 0);
      add(1, 4'hF, 0, 4'b0000, 2'd0, 0);
      // single requester 3, release, re-grant
      add(0, 4'h8, 0, 4'b1000, 2'd3, 1);
      add(0, 4'h8, 1, 4'b0000, 2'd3, 0);
      add(0, 4'h8, 0, 4'b1000, 2'd3, 1);
      add(0, 4'h8, 1, 4'b0000, 2'd3, 0);
      // rotation 0,1,2,3,0 with an idle cycle between grants
      add(0, 4'hF, 0, 4'b0001, 2'd0, 1);
      add(0, 4'hF, 1, 4'b0000, 2'd0, 0);
      add(0, 4'hF, 0, 4'b0010, 2'd1, 1);
      add(0, 4'hF, 1, 4'b0000, 2'd1, 0);
      add(0, 4'hF, 0, 4'b0100, 2'd2, 1);
      add(0, 4'hF, 1, 4'b0000, 2'd2, 0);
      add(0, 4'hF, 0, 4'b1000, 2'd3, 1);
      add(0, 4'hF, 1, 4'b0000, 2'd3, 0);
      add(0, 4'hF, 0, 4'b0001, 2'd0, 1);
      add(0, 4'hF, 1, 4'b0000, 2'd0, 0);
      // sparse requests and request drop
      add(1, 4'h0, 0, 4'b0000, 2'd0, 0);
      add(0, 4'hA, 0, 4'b0010, 2'd1, 1);
      add(0, 4'h8, 0, 4'b0000, 2'd1, 0);
      add(0, 4'hA, 0, 4'b1000, 2'd3, 1);
      add(0, 4'hA, 1, 4'b0000, 2'd3, 0);
      add(0, 4'hA, 0, 4'b0010, 2'd1, 1);
      add(0, 4'hA, 1, 4'b0000, 2'd1, 0);
      // done and request drop together, then done while idle
      add(0, 4'h8, 0, 4'b1000, 2'd3, 1);
      add(0, 4'h0, 1, 4'b0000, 2'd3, 0);
      add(0, 4'h0, 1, 4'b0000, 2'd3, 0);
      add(0, 4'h0, 0, 4'b0000, 2'd3, 0);
      // no preemption by other requesters
      add(0, 4'h4, 0, 4'b0100, 2'd2, 1);
      add(0, 4'hF, 0, 4'b0100, 2'd2, 1);
      add(0, 4'hF, 0, 4'b0100, 2'd2, 1);
      // reset mid-grant on index 2, then pointer restarts at 0
      add(1, 4'hF, 0, 4'b0000, 2'd0, 0);
      add(0, 4'h9, 0, 4'b0001, 2'd0, 1);
      add(0, 4'h9, 1, 4'b0000, 2'd0, 0);
      add(0, 4'h9, 0, 4'b1000, 2'd3, 1);
      add(0, 4'h9, 1, 4'b0000, 2'd3, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].done);
         check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].din, vecs[i].en, 1'b0);
      end

      // long hold on requester 0 with requester 2 waiting
      step(1, 4'b0101, 0);
      check("hold_reset", 4'b0000, 2'd0, 0, 0);
`ifdef DECODER_ARBITER_TIMEOUT_EN
      for (int c = 0; c < 4; c++) begin
         step(0, 4'b0101, 0);
         check($sformatf("hold_cyc%0d", c), 4'b0001, 2'd0, 1, 0);
      end
      step(0, 4'b0101, 0);
      check("timeout_pulse", 4'b0000, 2'd0, 0, 1);
      step(0, 4'b0101, 0);
      check("after_timeout", 4'b0100, 2'd2, 1, 0);
`else
      for (int c = 0; c < 20; c++) begin
         step(0, 4'b0101, 0);
         check($sformatf("hold_cyc%0d", c), 4'b0001, 2'd0, 1, 0);
      end
      step(0, 4'b0101, 1);
      check("hold_release", 4'b0000, 2'd0, 0, 0);
      step(0, 4'b0101, 0);
      check("after_hold", 4'b0100, 2'd2, 1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
